ps2_rx_frame: RTL
=================

Name: ps2_rx_frame

Overview:
- Upstream receive stage for the keyboard decoder. Samples raw PS2_CLK/PS2_DAT in the Clock_50 domain, filters glitches, and assembles 11-bit PS/2 device-to-host frames.
- Emits one validated scan-code byte per frame as a single-cycle strobe.
- The key-flag / multi-byte history logic consumes its output and no longer clocks on PS2_CLK directly.

Parameters:
FILTER_LEN, 8, consecutive identical Clock_50 samples required before a filtered line changes value (range 2..255)
TIMEOUT_CYCLES, 100000, Clock_50 cycles without a PS2_CLK falling edge before a partial frame is aborted (2 ms at 50 MHz)

Ports:
Clock_50  in  1  system clock, 50 MHz; all state on its rising edge
Reset  in  1  synchronous, active-high reset
PS2_CLK  in  1  raw asynchronous PS/2 clock line
PS2_DAT  in  1  raw asynchronous PS/2 data line
rx_data  out  8  last good byte; held until the next rx_valid
rx_valid  out  1  one-cycle strobe: rx_data updated this cycle
rx_error  out  1  one-cycle strobe: frame rejected
rx_err_code  out  2  0 none, 1 parity, 2 stop bit low, 3 timeout; valid with rx_error, held until the next rx_error
rx_busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Clock and reset: single clock domain (Clock_50); Reset is synchronous and active-high.
- Synchronizer: 2-FF synchronizer on each raw line; flops reset to 1.
- Line filter:
  - A per-line counter runs while the synchronized value differs from the filtered value.
  - The filtered value flips when the counter reaches FILTER_LEN-1.
  - The counter clears when the two values agree.
  - Filtered outputs reset to 1.
- fall: filtered clock was 1 last cycle and is 0 this cycle; one-cycle event.
- Data sampling: the filtered data value is sampled in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: fall with data=0 -> DATA, bit_cnt=0. Fall with data=1 is ignored (stays IDLE).
  - DATA: each fall shifts the sample in LSB-first (shreg <= {dat, shreg[7:1]}) and increments bit_cnt. The fall that makes bit_cnt reach 8 -> PARITY.
  - PARITY: fall stores the parity bit -> STOP.
  - STOP: on fall, always -> IDLE, and:
    - if ^{shreg, parity} != 1 (odd parity fails): rx_error=1, code 1;
    - else if stop sample = 0: rx_error=1, code 2;
    - else: rx_data <= shreg, rx_valid=1.
  - Parity failure takes priority over stop failure.
- Outputs on reject: rx_data is unchanged whenever a frame is rejected. rx_valid and rx_error are never high in the same cycle.
- Latency: rx_valid rises FILTER_LEN+3 Clock_50 cycles (±1) after the raw stop-bit falling edge. The exact count is deterministic for a clean input and documented by the bench.
- Reset values:
  - rx_data=0x00, rx_valid=0, rx_error=0, rx_err_code=0, rx_busy=0.
  - FSM=IDLE, bit_cnt=0, shreg=0.
  - Filter counters 0, timeout counter 0.
- Reset mid-frame: partial frame discarded, no strobe. Reset dominates any simultaneous fall.
- Reset released while the line is mid-frame: a low filtered clock following reset may be taken as a start bit. The resulting garbage frame must be rejected by the parity, stop or timeout checks, never delivered as valid.
- Glitch rejection: a PS2_CLK pulse shorter than FILTER_LEN cycles produces no fall.
- Back-to-back frames: IDLE accepts a new start bit on the very next fall after STOP; no dead time.

Optional Feature:
Macro PS2_RX_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on every fall and in IDLE, and increments otherwise.
  - On reaching TIMEOUT_CYCLES: FSM -> IDLE, rx_error=1, rx_err_code=3, shreg cleared.
  - A fall in the same cycle as expiry wins: the counter clears and no timeout is raised.
- Not defined:
  - No counter is present.
  - A truncated frame stalls until later edges complete it; code 3 is never produced.

Decomposition:
- Package ps2_pkg holds:
  - PS2_FRAME_BITS=11;
  - scan-code constants BREAK=0xF0, EXTENDED=0xE0;
  - the error-code enum/localparams ERR_NONE/ERR_PARITY/ERR_STOP/ERR_TIMEOUT;
  - FSM state encoding.
- One sub-module, ps2_line_filter (synchronizer plus FILTER_LEN filter), instantiated twice: once for clock, once for data.

Test Plan:
- Clean frame for 0x1D (start 0, bits 1,0,1,1,1,0,0,0, parity 1, stop 1), 12.5 kHz bit rate -> exactly one rx_valid, rx_data=0x1D, rx_error never high.
- Sequence E0,F0,75 back-to-back -> three rx_valid strobes in order carrying 0xE0, 0xF0, 0x75; rx_busy low between frames.
- Frame 0x1C with the parity bit flipped to 1 -> rx_error, rx_err_code=1, rx_data keeps its previous value.
- Frame 0x23 with stop bit 0 -> rx_error, code 2.
- 40 ns (2-cycle) low glitches on PS2_CLK during IDLE and mid-frame, FILTER_LEN=8 -> no extra bits counted; the frame still decodes correctly.
- With PS2_RX_TIMEOUT_EN, stop the clock after 5 bits -> exactly 100000 cycles after the last fall: rx_error, code 3, rx_busy=0. A following clean 0x29 frame is received correctly.
- Additionally, assert Reset after bit 4 of a frame -> no strobe, all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame size, well-known
// scan-code prefixes, error codes and receiver FSM encoding.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] BREAK    = 8'hF0;
  localparam logic [7:0] EXTENDED = 8'hE0;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PARITY  = 2'd1,
    ERR_STOP    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/ps2_rx_frame_if.sv
// PS/2 line inputs and decoded-byte outputs of the frame receiver.
// master: the receiver (samples the lines, drives the rx_* results).
// slave : the line driver / byte consumer.
interface ps2_rx_frame_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic [1:0] rx_err_code;
  logic       rx_busy;

  modport master (
    input  PS2_CLK, PS2_DAT,
    output rx_data, rx_valid, rx_error, rx_err_code, rx_busy
  );

  modport slave (
    output PS2_CLK, PS2_DAT,
    input  rx_data, rx_valid, rx_error, rx_err_code, rx_busy
  );
endinterface

// File: rtl/ps2_line_filter.sv
// One raw PS/2 line: 2-FF synchronizer followed by a persistence filter.
// The filtered value only follows the synchronized value once it has
// disagreed for FILTER_LEN consecutive cycles; any agreement restarts it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt
);

  logic       r_sync1, r_sync2;
  logic [7:0] r_cnt;
  logic       r_filt;

  // Metastability guard; idle PS/2 lines are high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count disagreeing samples; flip the filtered value on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else if (r_sync2 == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == 8'(FILTER_LEN - 1)) begin
      r_cnt  <= '0;
      r_filt <= r_sync2;
    end else begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver in the Clock_50 domain.
// Filters both lines, detects filtered PS2_CLK falling edges and assembles
// start/8 data/odd parity/stop frames into single-cycle byte strobes.
// Optional: define PS2_RX_TIMEOUT_EN to abort frames whose clock stalls
// for TIMEOUT_CYCLES cycles (reported as error code 3).
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          Clock_50,
  input  logic          Reset,
  ps2_rx_frame_if.master bus
);

  if (FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_bad_filter_len
    $error("ps2_rx_frame: FILTER_LEN must be in 2..255");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ps2_rx_frame: TIMEOUT_CYCLES must be at least 2");
  end

  logic      w_clk_f, w_dat_f, w_fall, w_timeout;
  logic      r_clk_prev;
  rx_state_e r_state, w_next;
  logic      w_deliver, w_reject;
  err_code_e w_code;

  logic [3:0] r_bit_cnt;
  logic [7:0] r_shreg;
  logic       r_parity;
  logic [7:0] r_data;
  logic       r_valid, r_error;
  err_code_e  r_code;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(Clock_50), .rst(Reset), .i_raw(bus.PS2_CLK), .o_filt(w_clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(Clock_50), .rst(Reset), .i_raw(bus.PS2_DAT), .o_filt(w_dat_f)
  );

  // Previous filtered clock, for the one-cycle falling-edge event.
  always_ff @(posedge Clock_50) begin
    if (Reset) r_clk_prev <= 1'b1;
    else       r_clk_prev <= w_clk_f;
  end

  assign w_fall = r_clk_prev & ~w_clk_f;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // A fall in the expiry cycle wins, so the timeout is masked by w_fall.
  assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Cycles since the last fall while a frame is open.
  always_ff @(posedge Clock_50) begin
    if (Reset || w_fall || w_timeout || r_state == ST_IDLE) r_tmo_cnt <= '0;
    else                                                   r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge Clock_50) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state plus the end-of-frame verdict.
  always_comb begin
    w_next    = r_state;
    w_deliver = 1'b0;
    w_reject  = 1'b0;
    w_code    = ERR_NONE;
    unique case (r_state)
      ST_IDLE:   if (w_fall && !w_dat_f) w_next = ST_DATA;
      ST_DATA:   if (w_fall && r_bit_cnt == 4'd7) w_next = ST_PARITY;
      ST_PARITY: if (w_fall) w_next = ST_STOP;
      ST_STOP: begin
        if (w_fall) begin
          w_next = ST_IDLE;
          if (^{r_shreg, r_parity} != 1'b1) begin
            w_reject = 1'b1;
            w_code   = ERR_PARITY;
          end else if (!w_dat_f) begin
            w_reject = 1'b1;
            w_code   = ERR_STOP;
          end else begin
            w_deliver = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_next   = ST_IDLE;
      w_reject = 1'b1;
      w_code   = ERR_TIMEOUT;
    end
  end

  // Bit capture and registered result outputs.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_parity  <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_code    <= ERR_NONE;
    end else begin
      r_valid <= w_deliver;
      r_error <= w_reject;
      if (w_reject)  r_code <= w_code;
      if (w_deliver) r_data <= r_shreg;
      if (w_timeout) begin
        r_shreg <= '0;
      end else if (w_fall) begin
        unique case (r_state)
          ST_IDLE:   if (!w_dat_f) r_bit_cnt <= '0;
          ST_DATA: begin
            r_shreg   <= {w_dat_f, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          ST_PARITY: r_parity <= w_dat_f;
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_data     = r_data;
  assign bus.rx_valid    = r_valid;
  assign bus.rx_error    = r_error;
  assign bus.rx_err_code = r_code;
  assign bus.rx_busy     = (r_state != ST_IDLE);

endmodule
